// File: rtl/cla_pkg.sv
// Shared constants and the propagate/generate combine used by the
// 4-bit lookahead group and the pipelined adder top.
package cla_pkg;

  localparam int GROUP_W = 4;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // hi is the more significant span, lo the less significant one
  function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
    pg_t r;
    r.p = hi.p & lo.p;
    r.g = hi.g | (hi.p & lo.g);
    return r;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group: sum, carry-out and the
// group propagate/generate used for whole-word lookahead.
module cla_group4
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] sum,
  output logic               cout,
  output logic               pg,
  output logic               gg
);

  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  // gg deliberately excludes cin so it can be chained across groups
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
  assign pg = &p;

  assign cout = gg | (pg & cin);
  assign sum  = p ^ c;

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: GPS lookahead groups per stage,
// L = WIDTH/(4*GPS) stages, valid/ready handshake with a global advance.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GPS   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             pg,
  output logic             gg
);

  localparam int SW = GROUP_W * GPS;
  localparam int L  = WIDTH / SW;

  // Rank k feeds stage k; rank L is the output register. In opa_q, bits
  // below k*SW already hold sum bits, bits above still hold operand A.
  logic             vld_q [0:L];
  logic [WIDTH-1:0] opa_q [0:L];
  logic [WIDTH-1:0] opb_q [0:L-1];
  logic             cy_q  [0:L];
  pg_t              acc_q [1:L];
  logic             ovf_q;

  logic [WIDTH-1:0] nxt_opa [1:L];
  logic             nxt_cy  [1:L];
  pg_t              nxt_acc [1:L];
  logic             nxt_ovf;
  logic             adv;

  assign adv      = !vld_q[L] | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < L; k++) begin : g_stage
    logic             c   [0:GPS];
    pg_t              acc [0:GPS];
    logic [SW-1:0]    s;
    logic [WIDTH-1:0] merged;

    assign c[0] = cy_q[k];

    if (k == 0) begin : g_first
      assign acc[0] = '{p: 1'b1, g: 1'b0};
    end else begin : g_rest
      assign acc[0] = acc_q[k];
    end

    for (genvar j = 0; j < GPS; j++) begin : g_grp
      localparam int LSB = (k * GPS + j) * GROUP_W;
      logic grp_p;
      logic grp_g;

      cla_group4 u_grp (
        .a    (opa_q[k][LSB +: GROUP_W]),
        .b    (opb_q[k][LSB +: GROUP_W]),
        .cin  (c[j]),
        .sum  (s[j*GROUP_W +: GROUP_W]),
        .cout (c[j+1]),
        .pg   (grp_p),
        .gg   (grp_g)
      );

      assign acc[j+1] = pg_combine('{p: grp_p, g: grp_g}, acc[j]);
    end

    always_comb begin
      merged              = opa_q[k];
      merged[k*SW +: SW]  = s;
    end

    assign nxt_opa[k+1] = merged;
    assign nxt_cy[k+1]  = c[GPS];
    assign nxt_acc[k+1] = acc[GPS];

    // Carry into the MSB is recovered from the MSB sum bit and its operands
    if (k == L - 1) begin : g_last
      assign nxt_ovf = c[GPS] ^ merged[WIDTH-1] ^ opa_q[k][WIDTH-1] ^ opb_q[k][WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= L; k++) begin
        vld_q[k] <= 1'b0;
        opa_q[k] <= '0;
        cy_q[k]  <= 1'b0;
      end
      for (int k = 0; k < L; k++) begin
        opb_q[k] <= '0;
      end
      for (int k = 1; k <= L; k++) begin
        acc_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      opa_q[0] <= a;
      opb_q[0] <= sub ? ~b : b;
      cy_q[0]  <= sub | cin;
      for (int k = 1; k <= L; k++) begin
        vld_q[k] <= vld_q[k-1];
        opa_q[k] <= nxt_opa[k];
        cy_q[k]  <= nxt_cy[k];
        acc_q[k] <= nxt_acc[k];
      end
      for (int k = 1; k < L; k++) begin
        opb_q[k] <= opb_q[k-1];
      end
      ovf_q <= nxt_ovf;
    end
  end

  assign out_valid = vld_q[L];
  assign sum       = opa_q[L];
  assign cout      = cy_q[L];
  assign ovf       = ovf_q;
  assign pg        = acc_q[L].p;
  assign gg        = acc_q[L].g;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder (WIDTH=16, GPS=2): arithmetic reference model with a
// scoreboard, directed literal vectors, back-pressure, mid-flight reset, random run.
module tb_cla_pipe_adder;

  localparam int W = 16;
  localparam int G = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         pg;
  logic         gg;

  int           n_cmp = 0;
  int           n_bad = 0;
  bit           rand_rdy = 1'b0;
  logic [W+3:0] exp_q [$];

  // res packs {sum, cout, ovf, pg, gg}
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W+3:0] res;
  } vec_t;

  vec_t vecs [9] = '{
    '{16'h00FF, 16'h0001, 1'b0, 1'b0, {16'h0100, 4'b0000}},
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 4'b1001}},
    '{16'hFFFF, 16'h0000, 1'b1, 1'b0, {16'h0000, 4'b1010}},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 4'b0100}},
    '{16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 4'b1101}},
    '{16'h0005, 16'h0007, 1'b1, 1'b1, {16'hFFFE, 4'b0000}},
    '{16'h1234, 16'h1234, 1'b0, 1'b1, {16'h0000, 4'b1010}},
    '{16'h8000, 16'h8000, 1'b0, 1'b0, {16'h0000, 4'b1101}},
    '{16'h1234, 16'h4321, 1'b1, 1'b0, {16'h5556, 4'b0000}}
  };

  cla_pipe_adder #(.WIDTH(W), .GPS(G)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .pg        (pg),
    .gg        (gg)
  );

  always #5 clk = ~clk;

  // Plain word arithmetic: full sum, signed-overflow by sign rule, gg as carry with zero carry-in
  function automatic logic [W+3:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
    logic [W-1:0] bx;
    logic [W:0]   full;
    logic [W:0]   gen;
    logic         ov;
    bx   = ms ? ~mb : mb;
    gen  = {1'b0, ma} + {1'b0, bx};
    full = gen + {{W{1'b0}}, (ms | mc)};
    ov   = (ma[W-1] == bx[W-1]) && (full[W-1] != ma[W-1]);
    return {full[W-1:0], full[W], ov, &(ma ^ bx), gen[W]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                               input logic tc, input logic ts);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    a = ta; b = tbv; cin = tc; sub = ts; in_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      n++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) checkOutput("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_empty", 32'(exp_q.size()), 32'(0));
  endtask

  // Scoreboard: push at acceptance, pop and compare at consumption
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) checkOutput("spurious_result", 32'(1), 32'(0));
        else checkOutput("result", 32'({sum, cout, ovf, pg, gg}), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 1) == 1);
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'(0));
    checkOutput("reset_in_ready", 32'(in_ready), 32'(1));
    checkOutput("reset_outputs", 32'({sum, cout, ovf, pg, gg}), 32'(0));
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i])
      checkOutput($sformatf("model_vec%0d", i),
                  32'(model(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub)), 32'(vecs[i].res));

    foreach (vecs[i]) applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
    drain();

    $display("[TB] back-pressure phase");
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 4; i++) applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      begin
        int m;
        m = 0;
        do begin
          @(negedge clk);
          m++;
        end while (!out_valid && m < 20);
        for (int s = 0; s < 5; s++) begin
          checkOutput("bp_in_ready", 32'(in_ready), 32'(0));
          checkOutput("bp_hold", 32'({sum, cout, ovf, pg, gg, out_valid}), 32'({vecs[0].res, 1'b1}));
          @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] mid-flight reset phase");
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
    applyStimulus(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    applyStimulus(16'h4000, 16'h0001, 1'b0, 1'b0);
    checkOutput("pre_reset_valid", 32'(out_valid), 32'(1));
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
    checkOutput("rst_outputs", 32'({sum, cout, ovf, pg, gg}), 32'(0));
    checkOutput("rst_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("rst_hold_valid", 32'(out_valid), 32'(0));
    rst_n = 1'b1;
    applyStimulus(16'h0003, 16'h0004, 1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    // accepted at edge E, visible after edge E+2: third falling edge from here
    checkOutput("latency_after_reset", 32'(n), 32'(3));
    @(posedge clk);
    #1;
    drain();

    $display("[TB] random phase");
    rand_rdy = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
